alu_instr_sequencer: RTL
========================

ALU_INSTR_SEQUENCER -- requirements
Module: alu_instr_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and clr.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- REG_COUNT, 16: number of general registers.
- WAIT_MAX, 15: maximum number of T1 cycles allowed waiting for mem_ready.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on its rising edge.
- clr, in, 1: asynchronous active-high reset.
- run, in, 1: when high in IDLE, start a fetch; also sampled at end of instruction.
- ir, in, 32: datapath IR contents. opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- mem_ready, in, 1: memory read data valid.
- pc_out, zlo_out, zhi_out, mdr_out, c_out, out, 1 each: bus drivers.
- mar_enable, pc_enable, pc_increment, mdr_enable, read, ir_enable, y_enable, z_enable, lo_in, hi_in, out, 1 each: register loads and memory control.
- r_in, out, REG_COUNT: one-hot general-register load.
- r_out, out, REG_COUNT: one-hot general-register bus drive.
- op_code, out, 5: ALU operation.
- done, out, 1: one-cycle pulse at instruction end.
- fault, out, 1: sticky error flag.

Function
REQ-004 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT; the state register SHALL be the only sequential element besides the wait counter.
REQ-005 All outputs SHALL be decoded combinationally from state and ir; any signal not listed for a state is 0.
REQ-006 IDLE: no outputs asserted; run=1 -> T0, else stay.
REQ-007 T0: pc_out, mar_enable, pc_increment, z_enable; -> T1.
REQ-008 T1: zlo_out, pc_enable, read, mdr_enable.
- mem_ready=1 -> T2.
- Otherwise stay in T1 and increment the wait counter.
- Counter reaching WAIT_MAX with mem_ready=0 -> FAULT.
- Counter clears on T1 entry.
- pc_enable SHALL assert only in the first T1 cycle.
REQ-009 T2: mdr_out, ir_enable; -> T3.
- Opcode classes: legal three-register = 3..11 (add,sub,shr,shra,shl,ror,rol,and,or); immediate = 12..14 (addi,andi,ori); mul/div = 15,16; unary = 17,18 (neg,not).
- ir SHALL be decoded from T3 onward.
REQ-010 T3, opcode legal: r_out[rb] and y_enable; for mul/div use r_out[ra].
- Unary: r_out[rb], op_code, z_enable; -> T5.
- Otherwise -> T4.
REQ-011 T3, opcode illegal (0..2 or 19..31): -> FAULT; no outputs asserted.
REQ-012 T4: op_code=opcode and z_enable, plus one bus driver by class; -> T5.
- Three-register: r_out[rc].
- Immediate: c_out.
- mul/div: r_out[rb].
REQ-013 T5: zlo_out plus one load by class.
- mul/div: lo_in; -> T6.
- All other classes: r_in[ra].
REQ-014 T6 (mul/div only): zhi_out, hi_in.
REQ-015 Last state of an instruction (T5 non-mul/div, T6 mul/div):
- done=1 for that cycle.
- run=1 -> T0, else -> IDLE.
REQ-016 FAULT: fault=1; all other outputs 0; leaves only via clr.
REQ-017 Register indices >= REG_COUNT SHALL produce all-zero r_in/r_out.
REQ-018 Latency:
- Three-register/immediate: 6 cycles T0..T5 with zero-wait memory.
- mul/div: 7 cycles.
- Unary: 5 cycles.
- Each memory wait cycle adds one cycle.

Reset
REQ-019 clr=1 SHALL immediately force IDLE, wait counter 0, and all outputs 0 (including fault), regardless of clk or current state.
REQ-020 After clr deasserts, no transition SHALL occur before the first rising clk edge with run=1.

Verification
REQ-021 shl R1,R2,R3, ir=0x38918000, mem_ready=1 in first T1 -> T3 r_out=0x0004,y_enable; T4 r_out=0x0008,op_code=7,z_enable; T5 zlo_out,r_in=0x0002,done.
REQ-022 mul R4,R5, ir=0x7A280000 -> T3 r_out=0x0010; T4 r_out=0x0020,op_code=15; T5 zlo_out,lo_in; T6 zhi_out,hi_in,done; total 7 cycles.
REQ-023 addi R1,R2,5, ir=0x60900005 -> T4 c_out=1,op_code=12,r_out=0; T5 r_in=0x0002.
REQ-024 mem_ready held 0 -> FAULT entered after 15 T1 cycles; fault stays 1 until clr; pc_enable high only in the first T1 cycle.
REQ-025 ir opcode 5'b10011 -> FAULT directly from T3; no r_in asserted.
REQ-026 clr pulsed mid-T4 -> all outputs 0 within the same cycle; IDLE; with run=1 held, the next instruction restarts at T0.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_instr_sequencer
//  Brief    : Hardwired control sequencer for a bus-based ALU datapath.
//             Fetches an instruction (T0-T2), then steps through the
//             execute states T3-T6 according to the opcode class.
//             Memory waits are bounded; a timeout or an illegal opcode
//             parks the sequencer in a sticky FAULT state.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_instr_sequencer #(
    parameter int REG_COUNT = 16,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 run,
    input  logic [31:0]          ir,
    input  logic                 mem_ready,
    output logic                 pc_out,
    output logic                 zlo_out,
    output logic                 zhi_out,
    output logic                 mdr_out,
    output logic                 c_out,
    output logic                 mar_enable,
    output logic                 pc_enable,
    output logic                 pc_increment,
    output logic                 mdr_enable,
    output logic                 read,
    output logic                 ir_enable,
    output logic                 y_enable,
    output logic                 z_enable,
    output logic                 lo_in,
    output logic                 hi_in,
    output logic [REG_COUNT-1:0] r_in,
    output logic [REG_COUNT-1:0] r_out,
    output logic [4:0]           op_code,
    output logic                 done,
    output logic                 fault
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_T0    = 4'd1;
    localparam logic [3:0] c_T1    = 4'd2;
    localparam logic [3:0] c_T2    = 4'd3;
    localparam logic [3:0] c_T3    = 4'd4;
    localparam logic [3:0] c_T4    = 4'd5;
    localparam logic [3:0] c_T5    = 4'd6;
    localparam logic [3:0] c_T6    = 4'd7;
    localparam logic [3:0] c_FAULT = 4'd8;

    localparam int              c_WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_MAX - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    logic [3:0]          state_q, state_d;
    logic [c_WAIT_W-1:0] wait_q,  wait_d;

    // Instruction fields and opcode classes
    logic [4:0] w_opc;
    logic [3:0] w_ra, w_rb, w_rc;
    logic       w_is_3reg, w_is_imm, w_is_muldiv, w_is_unary, w_is_legal;
    logic       w_unused_ir;

    assign w_opc       = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_is_3reg   = (w_opc >= 5'd3)  && (w_opc <= 5'd11);
    assign w_is_imm    = (w_opc >= 5'd12) && (w_opc <= 5'd14);
    assign w_is_muldiv = (w_opc == 5'd15) || (w_opc == 5'd16);
    assign w_is_unary  = (w_opc == 5'd17) || (w_opc == 5'd18);
    assign w_is_legal  = w_is_3reg || w_is_imm || w_is_muldiv || w_is_unary;
    // Immediate field is consumed by the datapath, not by the sequencer
    assign w_unused_ir = ^ir[14:0];

    // One-hot register select; indices beyond the register file select nothing
    function automatic logic [REG_COUNT-1:0] f_onehot(input logic [3:0] idx);
        logic [REG_COUNT-1:0] v;
        v = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    // State and wait-counter registers, cleared asynchronously by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= c_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic and memory-wait bookkeeping
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            c_IDLE:  if (run) state_d = c_T0;
            c_T0: begin
                state_d = c_T1;
                wait_d  = '0;
            end
            c_T1: begin
                if (mem_ready)                state_d = c_T2;
                else if (wait_q == c_WAIT_LAST) state_d = c_FAULT;
                else                          wait_d  = wait_q + c_WAIT_ONE;
            end
            c_T2:    state_d = c_T3;
            c_T3: begin
                if (!w_is_legal)     state_d = c_FAULT;
                else if (w_is_unary) state_d = c_T5;
                else                 state_d = c_T4;
            end
            c_T4:    state_d = c_T5;
            c_T5: begin
                if (w_is_muldiv) state_d = c_T6;
                else             state_d = run ? c_T0 : c_IDLE;
            end
            c_T6:    state_d = run ? c_T0 : c_IDLE;
            c_FAULT: state_d = c_FAULT;
            default: state_d = c_IDLE;
        endcase
    end

    // Control-word decode from current state and instruction register
    always_comb begin
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        c_out        = 1'b0;
        mar_enable   = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        mdr_enable   = 1'b0;
        read         = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        lo_in        = 1'b0;
        hi_in        = 1'b0;
        r_in         = '0;
        r_out        = '0;
        op_code      = 5'd0;
        done         = 1'b0;
        fault        = 1'b0;
        case (state_q)
            c_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
            end
            c_T1: begin
                zlo_out    = 1'b1;
                pc_enable  = (wait_q == '0);  // PC loads once, not on every wait cycle
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            c_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            c_T3: begin
                if (w_is_unary) begin
                    r_out    = f_onehot(w_rb);
                    op_code  = w_opc;
                    z_enable = 1'b1;
                end else if (w_is_muldiv) begin
                    r_out    = f_onehot(w_ra);
                    y_enable = 1'b1;
                end else if (w_is_legal) begin
                    r_out    = f_onehot(w_rb);
                    y_enable = 1'b1;
                end
            end
            c_T4: begin
                op_code  = w_opc;
                z_enable = 1'b1;
                if (w_is_imm)         c_out = 1'b1;
                else if (w_is_muldiv) r_out = f_onehot(w_rb);
                else                  r_out = f_onehot(w_rc);
            end
            c_T5: begin
                zlo_out = 1'b1;
                if (w_is_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    r_in = f_onehot(w_ra);
                    done = 1'b1;
                end
            end
            c_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
            c_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
